// File: rtl/reg_file_sb.sv
// Parametrised register file with registered read ports, optional forwarding,
// optional hardwired zero entry and a per-register busy scoreboard.
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit FORWARD    = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  writereg,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] writedata,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic [DATA_WIDTH-1:0] readdata1,
  output logic [DATA_WIDTH-1:0] readdata2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  alloc,
  input  logic [ADDR_WIDTH-1:0] alloc_rd,
  input  logic                  flush
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic                  busy1_q, busy1_d, busy2_q, busy2_d;
  logic                  wr_ok, alloc_ok, zero1, zero2;

  assign wr_ok    = writereg && !(ZERO_REG && (rd == '0));
  assign alloc_ok = alloc && !(ZERO_REG && (alloc_rd == '0));
  assign zero1    = ZERO_REG && (rs1 == '0);
  assign zero2    = ZERO_REG && (rs2 == '0);

  // Busy priority per entry: flush, then a newly issued producer, then writeback.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        busy_d[i] = 1'b0;
      end else if (alloc_ok && (alloc_rd == ADDR_WIDTH'(i))) begin
        busy_d[i] = 1'b1;
      end else if (wr_ok && (rd == ADDR_WIDTH'(i))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
  end

  always_comb begin
    rdata1_d = mem_q[rs1];
    if (FORWARD && wr_ok && (rd == rs1)) rdata1_d = writedata;
    if (zero1) rdata1_d = '0;
    busy1_d = FORWARD ? busy_d[rs1] : busy_q[rs1];
    if (zero1) busy1_d = 1'b0;

    rdata2_d = mem_q[rs2];
    if (FORWARD && wr_ok && (rd == rs2)) rdata2_d = writedata;
    if (zero2) rdata2_d = '0;
    busy2_d = FORWARD ? busy_d[rs2] : busy_q[rs2];
    if (zero2) busy2_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[rd] <= writedata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q   <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      busy1_q  <= 1'b0;
      busy2_q  <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      busy1_q  <= busy1_d;
      busy2_q  <= busy2_d;
    end
  end

  assign readdata1 = rdata1_q;
  assign readdata2 = rdata2_q;
  assign busy1     = busy1_q;
  assign busy2     = busy2_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: two instances (zero-reg+forwarding, and
// plain+no-forwarding) driven in lockstep and checked against a rule-level model.
module tb_reg_file_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int EW    = 4 * DW + 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          writereg = 1'b0;
  logic [AW-1:0] rd = '0;
  logic [DW-1:0] writedata = '0;
  logic [AW-1:0] rs1 = '0;
  logic [AW-1:0] rs2 = '0;
  logic          alloc = 1'b0;
  logic [AW-1:0] alloc_rd = '0;
  logic          flush = 1'b0;

  logic [DW-1:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic          a_b1, a_b2, b_b1, b_b2;

  // Clock and reset
  always #5 clock = ~clock;

  reg_file_sb u_dut_a (
    .clock(clock), .reset(reset), .writereg(writereg), .rd(rd), .writedata(writedata),
    .rs1(rs1), .rs2(rs2), .readdata1(a_rd1), .readdata2(a_rd2), .busy1(a_b1), .busy2(a_b2),
    .alloc(alloc), .alloc_rd(alloc_rd), .flush(flush)
  );

  reg_file_sb #(.ZERO_REG(1'b0), .FORWARD(1'b0)) u_dut_b (
    .clock(clock), .reset(reset), .writereg(writereg), .rd(rd), .writedata(writedata),
    .rs1(rs1), .rs2(rs2), .readdata1(b_rd1), .readdata2(b_rd2), .busy1(b_b1), .busy2(b_b2),
    .alloc(alloc), .alloc_rd(alloc_rd), .flush(flush)
  );

  // Reference model: config 0 = ZERO_REG/FORWARD on, config 1 = both off
  logic [DW-1:0] m_mem  [2][DEPTH];
  bit            m_busy [2][DEPTH];
  logic [EW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic model_clear();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[c][i]  = '0;
        m_busy[c][i] = 1'b0;
      end
  endtask

  task automatic model_cycle(input int c, output logic [DW-1:0] e1, output logic [DW-1:0] e2,
                             output logic eb1, output logic eb2);
    bit zr = (c == 0);
    bit fw = (c == 0);
    bit wr_ok = writereg && !(zr && rd == 0);
    e1  = (zr && rs1 == 0) ? '0 : (fw && wr_ok && rd == rs1) ? writedata : m_mem[c][rs1];
    e2  = (zr && rs2 == 0) ? '0 : (fw && wr_ok && rd == rs2) ? writedata : m_mem[c][rs2];
    eb1 = m_busy[c][rs1];
    eb2 = m_busy[c][rs2];
    // Apply the rules lowest priority first so later ones override
    if (wr_ok) begin
      m_mem[c][rd]  = writedata;
      m_busy[c][rd] = 1'b0;
    end
    if (alloc && !(zr && alloc_rd == 0)) m_busy[c][alloc_rd] = 1'b1;
    if (flush) for (int i = 0; i < DEPTH; i++) m_busy[c][i] = 1'b0;
    if (fw) begin
      eb1 = m_busy[c][rs1];
      eb2 = m_busy[c][rs2];
    end
    if (zr && rs1 == 0) eb1 = 1'b0;
    if (zr && rs2 == 0) eb2 = 1'b0;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic we, input logic [AW-1:0] w_rd, input logic [DW-1:0] wd,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic al, input logic [AW-1:0] ard, input logic fl);
    logic [DW-1:0] ea1, ea2, eb1, eb2;
    logic          fa1, fa2, fb1, fb2;
    @(negedge clock);
    #1;
    writereg = we; rd = w_rd; writedata = wd; rs1 = a1; rs2 = a2;
    alloc = al; alloc_rd = ard; flush = fl;
    model_cycle(0, ea1, ea2, fa1, fa2);
    model_cycle(1, eb1, eb2, fb1, fb2);
    exp_q.push_back({ea1, ea2, eb1, eb2, fa1, fa2, fb1, fb2});
  endtask

  task automatic read_only(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    drive(1'b0, '0, '0, a1, a2, 1'b0, '0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_rd1"}, a_rd1, '0);
    check({tag, "_a_rd2"}, a_rd2, '0);
    check({tag, "_a_b1"}, DW'(a_b1), '0);
    check({tag, "_a_b2"}, DW'(a_b2), '0);
    check({tag, "_b_rd1"}, b_rd1, '0);
    check({tag, "_b_rd2"}, b_rd2, '0);
    check({tag, "_b_b1"}, DW'(b_b1), '0);
    check({tag, "_b_b2"}, DW'(b_b2), '0);
  endtask

  // Mid-cycle reset with a write and alloc held during it; both must be discarded.
  task automatic do_reset();
    @(negedge clock);
    #1;
    reset = 1'b0;
    writereg = 1'b1; rd = 5'd5; writedata = $urandom; alloc = 1'b1; alloc_rd = 5'd5;
    flush = 1'b0; rs1 = 5'd5; rs2 = 5'd5;
    #1;
    check_all_zero("async_rst");
    model_clear();
    repeat (2) @(negedge clock);
    #1;
    writereg = 1'b0; alloc = 1'b0;
    reset = 1'b1;
  endtask

  // Scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("a_readdata1", a_rd1, e[4*DW+3 -: DW]);
        check("a_readdata2", a_rd2, e[3*DW+3 -: DW]);
        check("b_readdata1", b_rd1, e[2*DW+3 -: DW]);
        check("b_readdata2", b_rd2, e[DW+3 -: DW]);
        check("a_busy1", DW'(a_b1), DW'(e[3]));
        check("a_busy2", DW'(a_b2), DW'(e[2]));
        check("b_busy1", DW'(b_b1), DW'(e[1]));
        check("b_busy2", DW'(b_b2), DW'(e[0]));
      end
    end
  end

  // Stimulus
  initial begin
    int waited;
    logic [AW-1:0] r_rd, r_s1, r_s2, r_al;
    model_clear();
    #3;
    check_all_zero("por");
    @(negedge clock);
    #1;
    reset = 1'b1;

    // Reset wipes earlier data
    drive(1'b1, 5'd5, 32'hDEADBEEF, '0, '0, 1'b0, '0, 1'b0);
    do_reset();
    read_only(5'd5, 5'd5);

    // Write then read latency, both ports
    drive(1'b1, 5'd3, 32'h12345678, '0, '0, 1'b0, '0, 1'b0);
    read_only(5'd3, 5'd3);

    // Same-edge write/read forwarding
    drive(1'b1, 5'd7, 32'h00000001, '0, '0, 1'b0, '0, 1'b0);
    drive(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1'b0, '0, 1'b0);
    read_only(5'd7, 5'd7);

    // Zero register write + alloc
    drive(1'b1, 5'd0, 32'hFFFFFFFF, '0, '0, 1'b1, 5'd0, 1'b0);
    read_only(5'd0, 5'd0);

    // Scoreboard sequence on r9
    drive(1'b0, '0, '0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0);
    read_only(5'd9, 5'd9);
    drive(1'b1, 5'd9, 32'h55, 5'd9, 5'd9, 1'b0, '0, 1'b0);
    read_only(5'd9, 5'd9);
    drive(1'b1, 5'd9, 32'h66, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0);
    read_only(5'd9, 5'd9);

    // Flush beats a same-edge alloc
    drive(1'b0, '0, '0, '0, '0, 1'b1, 5'd1, 1'b0);
    drive(1'b0, '0, '0, '0, '0, 1'b1, 5'd2, 1'b0);
    drive(1'b0, '0, '0, 5'd1, 5'd2, 1'b1, 5'd4, 1'b0);
    drive(1'b0, '0, '0, 5'd4, 5'd6, 1'b1, 5'd6, 1'b1);
    read_only(5'd1, 5'd2);
    read_only(5'd4, 5'd6);
    read_only(5'd3, 5'd9);

    // Randomised traffic, indices biased to a small window to force collisions
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      r_rd = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      r_s1 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      r_s2 = ($urandom_range(0, 3) == 0) ? r_s1 : AW'($urandom_range(0, 7));
      r_al = ($urandom_range(0, 1) == 0) ? r_rd : AW'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), r_rd, $urandom, r_s1, r_s2,
            1'($urandom_range(0, 9) < 3), r_al, 1'($urandom_range(0, 19) == 0));
    end
    read_only('0, '0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clock);
      waited++;
    end
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
